// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: shares the single fifo_memory write port between NUM_REQ
// producers using round-robin arbitration with burst locking. A granted producer
// keeps the port until its last beat or until MAX_BURST beats have been accepted.
// Optional statistics counters are built when FIFO_ARB_STATS_EN is defined.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 8
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]              req_last,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            fifo_write_enable,
    output logic [DATA_WIDTH-1:0]           fifo_write_data,
    input  logic                            fifo_full,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]           stat_beats,
    output logic [15:0]                     stat_full_stall
`endif
);

    localparam int                IDX_W       = $clog2(NUM_REQ);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NUM_REQ - 1);
    localparam logic [7:0]        MAX_BURST_C = 8'(MAX_BURST);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  rrPtr_q, rrPtr_d;
    logic [IDX_W-1:0]  grantId_q, grantId_d;
    logic [7:0]        beatCnt_q, beatCnt_d;

    logic                   ownerValid;
    logic                   ownerLast;
    logic [DATA_WIDTH-1:0]  ownerData;
    logic                   beatAccept;
    logic                   burstEnd;
    logic [IDX_W-1:0]       pickIdx;
    logic [IDX_W-1:0]       candIdx;
    int                     cand;

    // Select the current owner's valid/last/data lanes out of the producer buses
    always_comb begin
        ownerValid = req_valid[grantId_q];
        ownerLast  = req_last[grantId_q];
        ownerData  = req_data[grantId_q*DATA_WIDTH +: DATA_WIDTH];
    end

    // Zero-latency beat path: only the owner sees ready, and nothing moves while the FIFO is full
    always_comb begin
        req_ready         = '0;
        fifo_write_enable = 1'b0;
        fifo_write_data   = '0;
        beatAccept        = 1'b0;
        burstEnd          = 1'b0;
        if (state_q == GRANT) begin
            req_ready[grantId_q] = !fifo_full;
            fifo_write_enable    = ownerValid & !fifo_full;
            fifo_write_data      = ownerData;
            beatAccept           = ownerValid & !fifo_full;
            burstEnd             = beatAccept & (ownerLast | ((beatCnt_q + 8'd1) == MAX_BURST_C));
        end
    end

    // Round-robin search starting at rrPtr; walking downward lets the nearest requester win
    always_comb begin
        pickIdx = rrPtr_q;
        cand    = 0;
        candIdx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = int'(rrPtr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            candIdx = IDX_W'(cand);
            if (req_valid[candIdx]) begin
                pickIdx = candIdx;
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, count beats and detect burst end in GRANT
    always_comb begin
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        grantId_d = grantId_q;
        beatCnt_d = beatCnt_q;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    state_d   = GRANT;
                    grantId_d = pickIdx;
                    beatCnt_d = '0;
                end
            end
            GRANT: begin
                if (beatAccept) begin
                    beatCnt_d = beatCnt_q + 8'd1;
                end
                if (burstEnd) begin
                    state_d = IDLE;
                    rrPtr_d = (grantId_q == LAST_IDX) ? '0 : grantId_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset abandons any burst in flight
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            rrPtr_q   <= '0;
            grantId_q <= '0;
            beatCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            grantId_q <= grantId_d;
            beatCnt_q <= beatCnt_d;
        end
    end

    assign busy     = (state_q == GRANT);
    assign grant_id = grantId_q;

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] statBeats_q [NUM_REQ];
    logic [15:0] statFullStall_q;

    // Saturating per-producer beat counters and full-stall cycle counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                statBeats_q[k] <= '0;
            end
            statFullStall_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (beatAccept && (grantId_q == IDX_W'(k)) && (statBeats_q[k] != 16'hFFFF)) begin
                    statBeats_q[k] <= statBeats_q[k] + 16'd1;
                end
            end
            if ((state_q == GRANT) && ownerValid && fifo_full && (statFullStall_q != 16'hFFFF)) begin
                statFullStall_q <= statFullStall_q + 16'd1;
            end
        end
    end

    // Flatten the per-producer counters onto the output bus
    always_comb begin
        stat_beats = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            stat_beats[k*16 +: 16] = statBeats_q[k];
        end
        stat_full_stall = statFullStall_q;
    end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Testbench for fifo_write_arbiter: a vector table for the basic beat path, then
// queue-driven producers checked every cycle against an abstract ownership model,
// with a bench-side 32-entry FIFO whose readout is compared to the expected stream.
module tb_fifo_write_arbiter;

    localparam int DW    = 8;
    localparam int NR    = 4;
    localparam int MB    = 8;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic              fifo_write_enable;
    logic [DW-1:0]     fifo_write_data;
    logic              fifo_full;
    logic [1:0]        grant_id;
    logic              busy;
`ifdef FIFO_ARB_STATS_EN
    logic [NR*16-1:0]  stat_beats;
    logic [15:0]       stat_full_stall;
`endif

    fifo_write_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk               (clk),
        .rstn              (rstn),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_last          (req_last),
        .req_ready         (req_ready),
        .fifo_write_enable (fifo_write_enable),
        .fifo_write_data   (fifo_write_data),
        .fifo_full         (fifo_full),
        .grant_id          (grant_id),
        .busy              (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_beats        (stat_beats),
        .stat_full_stall   (stat_full_stall)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    logic [8:0]    prodQ [NR][$];
    logic [7:0]    fifoMem[$];
    logic [7:0]    expStream[$];
    logic [NR-1:0] stallMask;
    int            drainProb;
    bit            drainOnce;
    int            writeCount;
    int            grantLog[$];
    bit            prevBusy;

    int mOwner;
    int mRr;
    int mCnt;

    typedef struct {
        logic [NR-1:0]    valid;
        logic [NR*DW-1:0] data;
        logic [NR-1:0]    last;
        logic             full;
        logic             expBusy;
        logic [1:0]       expGrant;
        logic [NR-1:0]    expReady;
        logic             expWe;
        logic [7:0]       expData;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic clearBench();
        for (int k = 0; k < NR; k++) prodQ[k].delete();
        fifoMem.delete();
        expStream.delete();
        grantLog.delete();
        stallMask  = '0;
        drainProb  = 0;
        drainOnce  = 1'b0;
        writeCount = 0;
        prevBusy   = 1'b0;
    endtask

    task automatic modelReset();
        mOwner = -1;
        mRr    = 0;
        mCnt   = 0;
    endtask

    task automatic applyReset();
        rstn      = 1'b0;
        req_valid = '1;
        req_data  = 32'hA5A5_A5A5;
        req_last  = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        clearBench();
        modelReset();
        checkOutput("reset_busy",  32'(busy), 32'd0);
        checkOutput("reset_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_we",    32'(fifo_write_enable), 32'd0);
        checkOutput("reset_data",  32'(fifo_write_data), 32'd0);
        checkOutput("reset_grant", 32'(grant_id), 32'd0);
        req_valid = '0;
        req_data  = '0;
    endtask

    // One clock of producer driving, output checking, FIFO bookkeeping and model update
    task automatic stepCycle();
        logic [NR-1:0]    v;
        logic [NR-1:0]    l;
        logic [NR*DW-1:0] d;
        logic [8:0]       head;
        logic [NR-1:0]    expReady;
        logic             expWe;
        logic [7:0]       expData;
        logic [7:0]       popped;
        bit               full;
        int               sizeBefore;
        v = '0; l = '0; d = '0;
        for (int k = 0; k < NR; k++) begin
            if (prodQ[k].size() > 0) begin
                head = prodQ[k][0];
                d[k*DW +: DW] = head[7:0];
                l[k] = head[8];
                v[k] = !stallMask[k];
            end
        end
        full = (fifoMem.size() >= DEPTH);
        req_valid = v;
        req_data  = d;
        req_last  = l;
        fifo_full = full;
        @(negedge clk);
        expReady = '0;
        expWe    = 1'b0;
        expData  = '0;
        if (mOwner >= 0) begin
            if (!full) expReady[mOwner] = 1'b1;
            expWe   = v[mOwner] & !full;
            expData = d[mOwner*DW +: DW];
        end
        checkOutput("busy",  32'(busy), (mOwner >= 0) ? 32'd1 : 32'd0);
        checkOutput("ready", 32'(req_ready), 32'(expReady));
        checkOutput("we",    32'(fifo_write_enable), 32'(expWe));
        checkOutput("wdata", 32'(fifo_write_data), 32'(expData));
        if (mOwner >= 0) checkOutput("grant_id", 32'(grant_id), 32'(mOwner));
        if (busy && !prevBusy) grantLog.push_back(int'(grant_id));
        prevBusy = busy;
        for (int k = 0; k < NR; k++) begin
            if (v[k] && req_ready[k] && prodQ[k].size() > 0) void'(prodQ[k].pop_front());
        end
        sizeBefore = fifoMem.size();
        if (fifo_write_enable) begin
            fifoMem.push_back(fifo_write_data);
            writeCount++;
        end
        if (mOwner < 0) begin
            for (int i = NR - 1; i >= 0; i--) begin
                if (v[(mRr + i) % NR]) mOwner = (mRr + i) % NR;
            end
            mCnt = 0;
        end else if (v[mOwner] && !full) begin
            expStream.push_back(d[mOwner*DW +: DW]);
            mCnt++;
            if (l[mOwner] || mCnt == MB) begin
                mRr    = (mOwner + 1) % NR;
                mOwner = -1;
            end
        end
        if (sizeBefore > 0 && (drainOnce || $urandom_range(99) < drainProb)) begin
            popped = fifoMem.pop_front();
            if (expStream.size() == 0) checkOutput("readout_extra", 32'(popped), 32'hFFFF_FFFF);
            else checkOutput("readout", 32'(popped), 32'(expStream.pop_front()));
        end
        drainOnce = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic runUntilIdle(input int maxCycles);
        bit done;
        done = 1'b0;
        for (int c = 0; c < maxCycles && !done; c++) begin
            stepCycle();
            done = (mOwner < 0);
            for (int k = 0; k < NR; k++) if (prodQ[k].size() > 0) done = 1'b0;
        end
        if (!done) checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic drainAll();
        logic [7:0] popped;
        while (fifoMem.size() > 0) begin
            popped = fifoMem.pop_front();
            if (expStream.size() == 0) checkOutput("drain_extra", 32'(popped), 32'hFFFF_FFFF);
            else checkOutput("drain", 32'(popped), 32'(expStream.pop_front()));
        end
        checkOutput("stream_left", 32'(expStream.size()), 32'd0);
    endtask

    task automatic applyStimulus(input int k, input int count, input logic [7:0] base, input bit withLast);
        for (int i = 0; i < count; i++) begin
            prodQ[k].push_back({withLast && (i == count - 1), base + 8'(i)});
        end
    endtask

    // Watchdog so the run always terminates
    initial begin
        #2000000;
        failCount++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] expOrder[10];
        int wc;

        vecs[0]  = '{4'b0001, 32'h0000_0010, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        vecs[1]  = '{4'b0001, 32'h0000_0010, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'h10};
        vecs[2]  = '{4'b0001, 32'h0000_0011, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'h11};
        vecs[3]  = '{4'b0001, 32'h0000_0012, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'h12};
        vecs[4]  = '{4'b0001, 32'h0000_0013, 4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'h13};
        vecs[5]  = '{4'b0011, 32'h0000_5513, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        vecs[6]  = '{4'b0011, 32'h0000_5513, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0000, 1'b0, 8'h55};
        vecs[7]  = '{4'b0011, 32'h0000_5513, 4'b0010, 1'b0, 1'b1, 2'd1, 4'b0010, 1'b1, 8'h55};
        vecs[8]  = '{4'b0001, 32'h0000_0077, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};
        vecs[9]  = '{4'b0001, 32'h0000_0077, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'h77};
        vecs[10] = '{4'b0000, 32'h0000_0077, 4'b0000, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b0, 8'h77};
        vecs[11] = '{4'b0001, 32'h0000_0078, 4'b0001, 1'b0, 1'b1, 2'd0, 4'b0001, 1'b1, 8'h78};
        vecs[12] = '{4'b0000, 32'h0000_0000, 4'b0000, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b0, 8'h00};

        $display("[TB] start");
        applyReset();

        for (int i = 0; i < 13; i++) begin
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            req_last  = vecs[i].last;
            fifo_full = vecs[i].full;
            @(negedge clk);
            checkOutput($sformatf("vec%0d_busy", i),  32'(busy), 32'(vecs[i].expBusy));
            checkOutput($sformatf("vec%0d_ready", i), 32'(req_ready), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d_we", i),    32'(fifo_write_enable), 32'(vecs[i].expWe));
            checkOutput($sformatf("vec%0d_data", i),  32'(fifo_write_data), 32'(vecs[i].expData));
            if (vecs[i].expBusy) checkOutput($sformatf("vec%0d_grant", i), 32'(grant_id), 32'(vecs[i].expGrant));
            @(posedge clk);
            #1;
        end

        // Four producers with 2-beat bursts; producer 0 has a second burst
        applyReset();
        applyStimulus(0, 2, 8'h00, 1'b1);
        applyStimulus(1, 2, 8'h10, 1'b1);
        applyStimulus(2, 2, 8'h20, 1'b1);
        applyStimulus(3, 2, 8'h30, 1'b1);
        applyStimulus(0, 2, 8'h02, 1'b1);
        runUntilIdle(100);
        checkOutput("rr_grant_count", 32'(grantLog.size()), 32'd5);
        for (int i = 0; i < 5 && i < grantLog.size(); i++) begin
            checkOutput($sformatf("rr_grant%0d", i), 32'(grantLog[i]), 32'(i % NR));
        end
        expOrder = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h02, 8'h03};
        checkOutput("rr_fifo_count", 32'(fifoMem.size()), 32'd10);
        for (int i = 0; i < 10 && i < fifoMem.size(); i++) begin
            checkOutput($sformatf("rr_fifo%0d", i), 32'(fifoMem[i]), 32'(expOrder[i]));
        end
        drainAll();

        // Producer 2 streams 20 beats, producer 3 competes: MAX_BURST forces hand-over
        applyReset();
        applyStimulus(2, 20, 8'h40, 1'b1);
        applyStimulus(3, 4, 8'hC0, 1'b1);
        runUntilIdle(200);
        checkOutput("mb_grant_count", 32'(grantLog.size()), 32'd4);
        if (grantLog.size() >= 4) begin
            checkOutput("mb_grant0", 32'(grantLog[0]), 32'd2);
            checkOutput("mb_grant1", 32'(grantLog[1]), 32'd3);
            checkOutput("mb_grant2", 32'(grantLog[2]), 32'd2);
        end
        if (fifoMem.size() > 8) begin
            checkOutput("mb_beat7", 32'(fifoMem[7]), 32'h47);
            checkOutput("mb_beat8", 32'(fifoMem[8]), 32'hC0);
        end
        drainAll();

        // Fill the FIFO while producer 1 keeps sending, then drain a single entry
        applyReset();
        applyStimulus(1, 40, 8'h80, 1'b1);
        repeat (60) stepCycle();
        checkOutput("fill_writes", 32'(writeCount), 32'd32);
        checkOutput("fill_level",  32'(fifoMem.size()), 32'd32);
        wc = writeCount;
        repeat (5) stepCycle();
        checkOutput("full_no_write", 32'(writeCount), 32'(wc));
        checkOutput("full_grant",    32'(grant_id), 32'd1);
        drainOnce = 1'b1;
        repeat (6) stepCycle();
        checkOutput("drain_one_write", 32'(writeCount), 32'(wc + 1));
        drainProb = 50;
        runUntilIdle(200);
        drainAll();

        // Owner stalls for 3 cycles mid-burst while producer 0 waits
        applyReset();
        applyStimulus(3, 4, 8'hD0, 1'b1);
        repeat (3) stepCycle();
        applyStimulus(0, 2, 8'hE0, 1'b1);
        stallMask[3] = 1'b1;
        wc = writeCount;
        repeat (3) stepCycle();
        checkOutput("stall_no_write", 32'(writeCount), 32'(wc));
        checkOutput("stall_grant",    32'(grant_id), 32'd3);
        stallMask = '0;
        runUntilIdle(50);
        checkOutput("stall_grant_count", 32'(grantLog.size()), 32'd2);
        if (grantLog.size() >= 2) begin
            checkOutput("stall_order0", 32'(grantLog[0]), 32'd3);
            checkOutput("stall_order1", 32'(grantLog[1]), 32'd0);
        end
        drainAll();

        // Reset during a GRANT beat; arbitration must restart from pointer 0
        applyReset();
        applyStimulus(1, 2, 8'hA0, 1'b1);
        applyStimulus(2, 6, 8'hB0, 1'b1);
        repeat (6) stepCycle();
        rstn = 1'b0;
        stepCycle();
        rstn = 1'b1;
        checkOutput("midrst_busy",  32'(busy), 32'd0);
        checkOutput("midrst_ready", 32'(req_ready), 32'd0);
        checkOutput("midrst_we",    32'(fifo_write_enable), 32'd0);
        modelReset();
        for (int k = 0; k < NR; k++) prodQ[k].delete();
        grantLog.delete();
        prevBusy = 1'b0;
        applyStimulus(1, 1, 8'hA8, 1'b1);
        applyStimulus(3, 1, 8'hF0, 1'b1);
        runUntilIdle(50);
        if (grantLog.size() > 0) checkOutput("midrst_first_grant", 32'(grantLog[0]), 32'd1);
        else checkOutput("midrst_first_grant", 32'hFFFF_FFFF, 32'd1);
        drainAll();

        // Randomized traffic with stalls and random FIFO draining
        applyReset();
        drainProb = 55;
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < NR; k++) begin
                if (prodQ[k].size() == 0 && $urandom_range(99) < 15) begin
                    applyStimulus(k, int'($urandom_range(1, 20)), 8'($urandom), 1'b1);
                end
                stallMask[k] = ($urandom_range(99) < 20);
            end
            stepCycle();
        end
        stallMask = '0;
        runUntilIdle(1000);
        drainAll();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
